seg_mux_ctrl: RTL

Time-multiplexing scheduler that shares one combinational seven-segment decoder between two common-anode digits. It latches a coherent pair of 4-bit hex values and steers one value at a time onto the decoder input. It drives the matching active-low anode enable and inserts blanking intervals between digits to suppress ghosting. It sits between the digit sources (switches or a counter) and the decoder/anode pins at the top level.

---
 rtl/seg_mux_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_mux_ctrl.sv
// Two-digit time-multiplexing scheduler for a shared seven-segment decoder.
// Define SEG_MUX_BLANK_EN to build the anti-ghosting blank states between digits.
module seg_mux_ctrl #(
  parameter int HOLD_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] dig,
  output logic [1:0] an,
  output logic       frame,
  output logic [2:0] state_dbg
);

  localparam int MAXC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
`ifdef SEG_MUX_BLANK_EN
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    PARK   = 3'd0,
    SHOW0  = 3'd1,
    BLANK0 = 3'd2,
    SHOW1  = 3'd3,
    BLANK1 = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    sh0, sh0_d, sh1, sh1_d, dig_d;
  logic [1:0]    an_d;
  logic          frame_d;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PARK;
      cnt   <= '0;
      sh0   <= 4'h0;
      sh1   <= 4'h0;
      dig   <= 4'h0;
      an    <= 2'b11;
      frame <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sh0   <= sh0_d;
      sh1   <= sh1_d;
      dig   <= dig_d;
      an    <= an_d;
      frame <= frame_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh0_d   = sh0;
    sh1_d   = sh1;
    dig_d   = dig;
    an_d    = an;
    if (!en) begin
      // Park dark; dig keeps its last value.
      state_d = PARK;
      cnt_d   = '0;
      an_d    = 2'b11;
    end else begin
      case (state)
        PARK: begin
          state_d = SHOW0;
          sh0_d   = s0;
          sh1_d   = s1;
          dig_d   = s0;
          an_d    = 2'b10;
          cnt_d   = HOLD_LOAD;
        end
        SHOW0: begin
          if (cnt == '0) begin
`ifdef SEG_MUX_BLANK_EN
            state_d = BLANK0;
            an_d    = 2'b11;
            cnt_d   = BLANK_LOAD;
`else
            state_d = SHOW1;
            dig_d   = sh1;
            an_d    = 2'b01;
            cnt_d   = HOLD_LOAD;
`endif
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
`ifdef SEG_MUX_BLANK_EN
        BLANK0: begin
          if (cnt == '0) begin
            state_d = SHOW1;
            dig_d   = sh1;
            an_d    = 2'b01;
            cnt_d   = HOLD_LOAD;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        BLANK1: begin
          if (cnt == '0) begin
            state_d = SHOW0;
            sh0_d   = s0;
            sh1_d   = s1;
            dig_d   = s0;
            an_d    = 2'b10;
            cnt_d   = HOLD_LOAD;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
`endif
        SHOW1: begin
          if (cnt == '0) begin
`ifdef SEG_MUX_BLANK_EN
            state_d = BLANK1;
            an_d    = 2'b11;
            cnt_d   = BLANK_LOAD;
`else
            // Fresh sample for the next frame is taken on the same edge.
            state_d = SHOW0;
            sh0_d   = s0;
            sh1_d   = s1;
            dig_d   = s0;
            an_d    = 2'b10;
            cnt_d   = HOLD_LOAD;
`endif
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        default: begin
          state_d = PARK;
          cnt_d   = '0;
          an_d    = 2'b11;
        end
      endcase
    end
  end

  // frame is registered: raise it on the edge that enters the frame's last cycle.
`ifdef SEG_MUX_BLANK_EN
  assign frame_d = (state_d == BLANK1) && (cnt_d == '0);
`else
  assign frame_d = (state_d == SHOW1) && (cnt_d == '0);
`endif

endmodule
